// File: rtl/issue_buffer.sv
// Bundle queue between fetch and decode: drops Nop slots, issues one instruction per cycle.
// Latency: a bundle captured at edge N into an empty queue issues at edge N+1.
// Backpressure: issue_stall freezes issue; registered interlock freezes fetch when fewer than 2 entries are free.
// Optional perf counters: define ISSUE_BUFFER_PERF_CNT_EN.
module issue_buffer #(
    parameter int          DEPTH      = 4,
    parameter logic [5:0]  NOP_OPCODE = 6'b000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] bundle_in,
    input  logic [31:0] bundle_pc,
    input  logic        branch_flag,
    input  logic        issue_stall,
    output logic        interlock,
    output logic        issue_valid,
    output logic [31:0] issue_inst,
    output logic [31:0] issue_pc,
    output logic        issue_slot
`ifdef ISSUE_BUFFER_PERF_CNT_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_interlock
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] NOP_INST = {NOP_OPCODE, 26'b0};

    logic [63:0]   q_bundle [DEPTH];
    logic [31:0]   q_pc     [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          slot_ptr;

    logic          in_slot0_nop;
    logic          in_slot1_nop;
    logic          enq;
    logic [31:0]   head_slot0;
    logic [31:0]   head_slot1;
    logic          head_vld;
    logic          take_slot0;
    logic          deq;
    logic [AW:0]   count_nxt;
    logic          interlock_nxt;

    always_comb begin
        in_slot0_nop  = (bundle_in[63:58] == NOP_OPCODE);
        in_slot1_nop  = (bundle_in[31:26] == NOP_OPCODE);
        enq           = !interlock && !branch_flag && !(in_slot0_nop && in_slot1_nop);
        head_slot0    = q_bundle[rd_ptr][63:32];
        head_slot1    = q_bundle[rd_ptr][31:0];
        head_vld      = (count != '0);
        // Queued entries always hold at least one real slot, so slot1 is the fallback.
        take_slot0    = !slot_ptr && (head_slot0[31:26] != NOP_OPCODE);
        deq           = head_vld && !issue_stall &&
                        (!take_slot0 || (head_slot1[31:26] == NOP_OPCODE));
        count_nxt     = count + (AW+1)'(enq) - (AW+1)'(deq);
        interlock_nxt = (count_nxt > (AW+1)'(DEPTH - 2));
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_bundle[wr_ptr] <= bundle_in;
            q_pc[wr_ptr]     <= bundle_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            slot_ptr    <= 1'b0;
            interlock   <= 1'b0;
            issue_valid <= 1'b0;
            issue_inst  <= NOP_INST;
            issue_pc    <= '0;
            issue_slot  <= 1'b0;
        end else if (branch_flag) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            slot_ptr    <= 1'b0;
            interlock   <= 1'b0;
            issue_valid <= 1'b0;
            issue_inst  <= NOP_INST;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (!issue_stall) begin
                if (head_vld) begin
                    issue_valid <= 1'b1;
                    issue_inst  <= take_slot0 ? head_slot0 : head_slot1;
                    issue_pc    <= q_pc[rd_ptr];
                    issue_slot  <= !take_slot0;
                    if (deq) begin
                        rd_ptr   <= rd_ptr + AW'(1);
                        slot_ptr <= 1'b0;
                    end else begin
                        slot_ptr <= 1'b1;
                    end
                end else begin
                    issue_valid <= 1'b0;
                    issue_inst  <= NOP_INST;
                end
            end
            count     <= count_nxt;
            interlock <= interlock_nxt;
        end
    end

    // The interlock margin should make this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(enq && (count == (AW+1)'(DEPTH))));

`ifdef ISSUE_BUFFER_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued    <= '0;
            perf_interlock <= '0;
        end else begin
            if (issue_valid && !issue_stall) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (interlock) begin
                perf_interlock <= perf_interlock + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_buffer.sv
// Scoreboard bench for issue_buffer: stimulus pushes expected issues, a negedge monitor pops and compares.
module tb_issue_buffer;

    logic        clk;
    logic        rst;
    logic [63:0] bundle_in;
    logic [31:0] bundle_pc;
    logic        branch_flag;
    logic        issue_stall;
    logic        interlock;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [31:0] issue_pc;
    logic        issue_slot;
`ifdef ISSUE_BUFFER_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_interlock;
`endif

    issue_buffer #(.DEPTH(4), .NOP_OPCODE(6'b000000)) dut (
        .clk         (clk),
        .rst         (rst),
        .bundle_in   (bundle_in),
        .bundle_pc   (bundle_pc),
        .branch_flag (branch_flag),
        .issue_stall (issue_stall),
        .interlock   (interlock),
        .issue_valid (issue_valid),
        .issue_inst  (issue_inst),
        .issue_pc    (issue_pc),
        .issue_slot  (issue_slot)
`ifdef ISSUE_BUFFER_PERF_CNT_EN
        ,
        .perf_issued    (perf_issued),
        .perf_interlock (perf_interlock)
`endif
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        slot;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: an issue is consumed when valid is shown and decode is not stalling.
    always @(negedge clk) begin
        if (rst || branch_flag) begin
            expq.delete();
        end else if (issue_valid && !issue_stall) begin
            exp_t e;
            exp_t a;
            tests++;
            a = '{inst: issue_inst, pc: issue_pc, slot: issue_slot};
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_issue: got inst=%h pc=%h slot=%0d, required no issue",
                         issue_inst, issue_pc, issue_slot);
            end else begin
                e = expq.pop_front();
                if (a !== e) begin
                    fails++;
                    $display("FAIL issue_order: got inst=%h pc=%h slot=%0d, required inst=%h pc=%h slot=%0d",
                             a.inst, a.pc, a.slot, e.inst, e.pc, e.slot);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [63:0] b, input logic [31:0] pc, input logic br, input logic st);
        bundle_in   = b;
        bundle_pc   = pc;
        branch_flag = br;
        issue_stall = st;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bundle(input logic [63:0] b, input logic [31:0] pc);
        logic [63:0] bb;
        bb = b;
        if (bb[63:58] != 6'd0) expq.push_back('{inst: bb[63:32], pc: pc, slot: 1'b0});
        if (bb[31:26] != 6'd0) expq.push_back('{inst: bb[31:0],  pc: pc, slot: 1'b1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(64'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        // Reset with garbage on the fetch bus
        cyc(64'hDEAD_BEEF_F00D_CAFE, 32'h1234_5678, 1'b0, 1'b0);
        chk("reset_valid", 32'(issue_valid), 32'd0);
        chk("reset_interlock", 32'(interlock), 32'd0);
        cyc(64'hDEAD_BEEF_F00D_CAFE, 32'h1234_5678, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(64'd0, 32'd0, 1'b0, 1'b0);
            chk("post_reset_valid", 32'(issue_valid), 32'd0);
            chk("post_reset_inst", issue_inst, 32'h0000_0000);
            chk("post_reset_interlock", 32'(interlock), 32'd0);
        end

        // Two real slots: slot0 then slot1 on consecutive edges
        expect_bundle(64'h0400_0001_0800_0002, 32'h10);
        cyc(64'h0400_0001_0800_0002, 32'h10, 1'b0, 1'b0);
        chk("first_latency_valid", 32'(issue_valid), 32'd0);
        cyc(64'd0, 32'd0, 1'b0, 1'b0);
        chk("first_issue_inst", issue_inst, 32'h0400_0001);
        idle(2);
        chk("after_pair_valid", 32'(issue_valid), 32'd0);

        // Nop in slot0 is skipped; all-Nop bundle is never queued
        expect_bundle(64'h0000_0000_0C00_0003, 32'h20);
        cyc(64'h0000_0000_0C00_0003, 32'h20, 1'b0, 1'b0);
        cyc(64'h0000_0000_0000_0000, 32'h24, 1'b0, 1'b0);
        chk("nop_skip_slot", 32'(issue_slot), 32'd1);
        idle(3);
        chk("all_nop_ignored_valid", 32'(issue_valid), 32'd0);
        chk("all_nop_ignored_inst", issue_inst, 32'h0000_0000);

        // Stall while three bundles fill the queue; two more arrive under interlock
        expect_bundle(64'h0400_00A0_0400_00A1, 32'h30);
        expect_bundle(64'h0400_00B0_0400_00B1, 32'h40);
        expect_bundle(64'h0400_00C0_0400_00C1, 32'h50);
        cyc(64'h0400_00A0_0400_00A1, 32'h30, 1'b0, 1'b1);
        cyc(64'h0400_00B0_0400_00B1, 32'h40, 1'b0, 1'b1);
        chk("interlock_two_queued", 32'(interlock), 32'd0);
        cyc(64'h0400_00C0_0400_00C1, 32'h50, 1'b0, 1'b1);
        chk("interlock_rise", 32'(interlock), 32'd1);
        chk("stall_holds_valid", 32'(issue_valid), 32'd0);
        cyc(64'h0400_00D0_0400_00D1, 32'h60, 1'b0, 1'b1);
        cyc(64'h0400_00E0_0400_00E1, 32'h70, 1'b0, 1'b1);
        chk("interlock_held", 32'(interlock), 32'd1);
        cyc(64'd0, 32'd0, 1'b0, 1'b0);
        chk("interlock_after_release", 32'(interlock), 32'd1);
        chk("release_first_inst", issue_inst, 32'h0400_00A0);
        cyc(64'd0, 32'd0, 1'b0, 1'b0);
        chk("interlock_fall", 32'(interlock), 32'd0);
        idle(6);
        chk("drained_valid", 32'(issue_valid), 32'd0);
`ifdef ISSUE_BUFFER_PERF_CNT_EN
        chk("perf_issued", perf_issued, 32'd9);
        chk("perf_interlock", perf_interlock, 32'd4);
`endif

        // Flush after head slot0 issued, with stall also asserted
        expect_bundle(64'h1000_0001_1400_0002, 32'h60);
        expect_bundle(64'h1800_0003_1C00_0004, 32'h70);
        cyc(64'h1000_0001_1400_0002, 32'h60, 1'b0, 1'b0);
        cyc(64'h1800_0003_1C00_0004, 32'h70, 1'b0, 1'b0);
        chk("pre_flush_inst", issue_inst, 32'h1000_0001);
        chk("pre_flush_pc", issue_pc, 32'h60);
        cyc(64'h2C00_0009_3000_000A, 32'h90, 1'b1, 1'b1);
        chk("flush_valid", 32'(issue_valid), 32'd0);
        chk("flush_inst", issue_inst, 32'h0000_0000);
        chk("flush_interlock", 32'(interlock), 32'd0);
`ifdef ISSUE_BUFFER_PERF_CNT_EN
        chk("perf_issued_kept", perf_issued, 32'd9);
        chk("perf_interlock_kept", perf_interlock, 32'd4);
`endif
        expect_bundle(64'h2000_0005_2400_0006, 32'h80);
        cyc(64'h2000_0005_2400_0006, 32'h80, 1'b0, 1'b0);
        cyc(64'd0, 32'd0, 1'b0, 1'b0);
        chk("post_flush_slot", 32'(issue_slot), 32'd0);
        idle(4);
        chk("post_flush_drained", 32'(issue_valid), 32'd0);
`ifdef ISSUE_BUFFER_PERF_CNT_EN
        chk("perf_issued_after_flush", perf_issued, 32'd11);
`endif

        // Reset mid-operation discards a queued bundle
        cyc(64'h2800_0007_2C00_0008, 32'hA0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc(64'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(3);
        chk("reset_discard_valid", 32'(issue_valid), 32'd0);
`ifdef ISSUE_BUFFER_PERF_CNT_EN
        chk("perf_issued_rst", perf_issued, 32'd0);
        chk("perf_interlock_rst", perf_interlock, 32'd0);
`endif
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
